// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the counter run controller.
//  state_e      : controller FSM states
//  PRESC_W_DEF  : default prescaler width
//  LEN_W_DEF    : default burst length / gap / active-tick width
//  BURST_W      : width of the completed-burst counter
package counter_seq_pkg;

   localparam int unsigned PRESC_W_DEF = 8;
   localparam int unsigned LEN_W_DEF   = 8;
   localparam int unsigned BURST_W     = 8;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StGap,
      StDone
   } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between the pin-level controller and the counter run sequencer.
//  master : drives start/stop/config and the counter's active flag, observes status
//  slave  : the sequencer; consumes control, produces ce/clear/status
interface counter_sequencer_if
   import counter_seq_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF
) ();

   logic               start_i;
   logic               stop_i;
   logic               periodic_i;
   logic [PRESC_W-1:0] prescale_i;
   logic [LEN_W-1:0]   length_i;
   logic [LEN_W-1:0]   gap_i;
   logic               active_i;
   logic               ce_o;
   logic               cnt_n_reset_o;
   logic               busy_o;
   logic               done_o;
   logic [BURST_W-1:0] bursts_o;
   logic [LEN_W-1:0]   active_ticks_o;

   modport master (
      output start_i, stop_i, periodic_i, prescale_i, length_i, gap_i, active_i,
      input  ce_o, cnt_n_reset_o, busy_o, done_o, bursts_o, active_ticks_o
   );

   modport slave (
      input  start_i, stop_i, periodic_i, prescale_i, length_i, gap_i, active_i,
      output ce_o, cnt_n_reset_o, busy_o, done_o, bursts_o, active_ticks_o
   );

endinterface

// File: rtl/counter_sequencer_tick_prescaler.sv
// Free-running divider that emits one tick every limit_i+1 enabled cycles.
//  clk_i     : clock
//  n_reset_i : synchronous active-low reset
//  clear_i   : restart the count at 0 (wins over en_i)
//  en_i      : count this cycle
//  limit_i   : terminal count; tick period is limit_i+1
//  tick_o    : high in the enabled cycle where the count equals limit_i
module tick_prescaler #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         n_reset_i,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [W-1:0] limit_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         at_limit;

   assign at_limit = (cnt_q == limit_i);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = at_limit ? '0 : cnt_q + W'(1);
      end
   end

   always_comb begin
      tick_o = en_i & at_limit;
   end

   always_ff @(posedge clk_i) begin
      if (!n_reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for the counter block: issues prescaled clock-enable bursts, one-shot or
// periodic with an idle gap, and keeps burst / active-tick statistics.
//  clk_i     : clock, rising edge
//  n_reset_i : synchronous active-low reset
//  bus       : slave side of counter_sequencer_if (control in, ce/clear/status out)
// All outputs decode registered state only.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_DEF,
   parameter int unsigned LEN_W   = LEN_W_DEF
) (
   input logic                clk_i,
   input logic                n_reset_i,
   counter_sequencer_if.slave bus
);

   state_e state_q, state_d;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   gap_q, gap_d;
   logic               periodic_q, periodic_d;

   logic [LEN_W-1:0]   tick_q, tick_d;
   logic [LEN_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic [BURST_W-1:0] bursts_q, bursts_d;
   logic [LEN_W-1:0]   act_q, act_d;

   logic               presc_tick;
   logic               presc_en;
   logic               presc_clr;
   logic               accept;
   logic               burst_end;
   logic               gap_end;
   logic [LEN_W-1:0]   tick_inc;
   logic [LEN_W-1:0]   gap_inc;

   assign presc_en  = (state_q == StRun) || (state_q == StGap);
   assign presc_clr = (state_q == StClear);

   tick_prescaler #(
      .W (PRESC_W)
   ) u_prescaler (
      .clk_i     (clk_i),
      .n_reset_i (n_reset_i),
      .clear_i   (presc_clr),
      .en_i      (presc_en),
      .limit_i   (presc_q),
      .tick_o    (presc_tick)
   );

   // Counters never exceed their limit, so the increment cannot overflow before the compare.
   assign tick_inc  = tick_q + LEN_W'(1);
   assign gap_inc   = gap_cnt_q + LEN_W'(1);
   assign accept    = (state_q == StIdle) && bus.start_i && !bus.stop_i;
   assign burst_end = (state_q == StRun) && presc_tick && (tick_inc == len_q);
   assign gap_end   = (state_q == StGap) && presc_tick && (gap_inc == gap_q);

   // State register
   always_ff @(posedge clk_i) begin
      if (!n_reset_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (bus.length_i == '0) ? StDone : StClear;
            end
         end
         StClear: state_d = StRun;
         StRun: begin
            if (burst_end) begin
               if (!periodic_q) begin
                  state_d = StDone;
               end else begin
                  state_d = (gap_q != '0) ? StGap : StClear;
               end
            end
         end
         StGap: begin
            if (gap_end) begin
               state_d = StClear;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // Abort from any active state; statistics freeze below.
      if (bus.stop_i && (state_q != StIdle)) begin
         state_d = StIdle;
      end
   end

   // Configuration latch and statistics counters
   always_comb begin
      presc_d    = presc_q;
      len_d      = len_q;
      gap_d      = gap_q;
      periodic_d = periodic_q;
      tick_d     = tick_q;
      gap_cnt_d  = gap_cnt_q;
      bursts_d   = bursts_q;
      act_d      = act_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               presc_d    = bus.prescale_i;
               len_d      = bus.length_i;
               gap_d      = bus.gap_i;
               periodic_d = bus.periodic_i;
               tick_d     = '0;
               gap_cnt_d  = '0;
               bursts_d   = '0;
               act_d      = '0;
            end
         end
         StClear: begin
            // Drops any residue left by an earlier abort.
            tick_d    = '0;
            gap_cnt_d = '0;
         end
         StRun: begin
            if (presc_tick && !bus.stop_i) begin
               if (bus.active_i && (act_q != '1)) begin
                  act_d = act_q + LEN_W'(1);
               end
               if (burst_end) begin
                  tick_d = '0;
                  if (bursts_q != '1) begin
                     bursts_d = bursts_q + BURST_W'(1);
                  end
               end else begin
                  tick_d = tick_inc;
               end
            end
         end
         StGap: begin
            if (presc_tick && !bus.stop_i) begin
               gap_cnt_d = gap_end ? '0 : gap_inc;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!n_reset_i) begin
         presc_q    <= '0;
         len_q      <= '0;
         gap_q      <= '0;
         periodic_q <= 1'b0;
         tick_q     <= '0;
         gap_cnt_q  <= '0;
         bursts_q   <= '0;
         act_q      <= '0;
      end else begin
         presc_q    <= presc_d;
         len_q      <= len_d;
         gap_q      <= gap_d;
         periodic_q <= periodic_d;
         tick_q     <= tick_d;
         gap_cnt_q  <= gap_cnt_d;
         bursts_q   <= bursts_d;
         act_q      <= act_d;
      end
   end

   // Output decode
   always_comb begin
      bus.ce_o           = (state_q == StRun) && presc_tick;
      bus.cnt_n_reset_o  = (state_q != StClear);
      bus.busy_o         = (state_q != StIdle);
      bus.done_o         = (state_q == StDone);
      bus.bursts_o       = bursts_q;
      bus.active_ticks_o = act_q;
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: a table of one-shot runs checked cycle by cycle,
// plus hand-written periodic, abort, reset and saturation sequences.
module tb_counter_sequencer;

   logic clk;
   logic n_reset;
   int   checks;
   int   errors;

   counter_sequencer_if #(.PRESC_W(8), .LEN_W(8)) bus ();

   counter_sequencer #(
      .PRESC_W (8),
      .LEN_W   (8)
   ) u_dut (
      .clk_i     (clk),
      .n_reset_i (n_reset),
      .bus       (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  presc;
      logic [7:0]  len;
      logic        act;
      logic [31:0] ce_mask;   // bit c set => ce_o high in cycle c (start sampled at edge 0)
      int          done_cyc;
      logic [7:0]  bursts;
      logic [7:0]  act_ticks;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.start_i    = 1'b0;
      bus.stop_i     = 1'b0;
      bus.periodic_i = 1'b0;
      bus.prescale_i = 8'd0;
      bus.length_i   = 8'd0;
      bus.gap_i      = 8'd0;
      bus.active_i   = 1'b0;
   endtask

   // Present config with start during one cycle; returns just after edge 0.
   task automatic kick(input logic [7:0] p, input logic [7:0] l, input logic [7:0] g,
                       input logic per, input logic a);
      @(negedge clk);
      bus.prescale_i = p;
      bus.length_i   = l;
      bus.gap_i      = g;
      bus.periodic_i = per;
      bus.active_i   = a;
      bus.start_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.start_i    = 1'b0;
      // Config changes after acceptance must not matter.
      bus.prescale_i = 8'd7;
      bus.length_i   = 8'd9;
      bus.gap_i      = 8'd5;
   endtask

   initial begin
      logic [31:0] ce_m, clr_m, done_m, busy_m;
      logic [31:0] busy_exp, clr_exp;
      int          n_ce;
      logic        bad;

      checks = 0;
      errors = 0;
      idle_inputs();
      n_reset = 1'b0;

      vecs[0] = '{8'd0, 8'd4, 1'b0, 32'h0000_003C, 6,  8'd1, 8'd0};
      vecs[1] = '{8'd2, 8'd3, 1'b1, 32'h0000_0490, 11, 8'd1, 8'd3};
      vecs[2] = '{8'd1, 8'd2, 1'b1, 32'h0000_0028, 6,  8'd1, 8'd2};
      vecs[3] = '{8'd0, 8'd1, 1'b0, 32'h0000_0004, 3,  8'd1, 8'd0};
      vecs[4] = '{8'd3, 8'd2, 1'b1, 32'h0000_0220, 10, 8'd1, 8'd2};
      vecs[5] = '{8'd0, 8'd0, 1'b1, 32'h0000_0000, 1,  8'd0, 8'd0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_ce", 32'(bus.ce_o), 32'd0);
      check("rst_cnt_n_reset", 32'(bus.cnt_n_reset_o), 32'd1);
      check("rst_done", 32'(bus.done_o), 32'd0);
      check("rst_bursts", 32'(bus.bursts_o), 32'd0);
      check("rst_active_ticks", 32'(bus.active_ticks_o), 32'd0);

      // One-shot table
      for (int i = 0; i < 6; i++) begin
         ce_m = '0; clr_m = '0; done_m = '0; busy_m = '0;
         kick(vecs[i].presc, vecs[i].len, 8'd0, 1'b0, vecs[i].act);
         for (int c = 1; c < 32; c++) begin
            @(negedge clk);
            ce_m[c]   = bus.ce_o;
            clr_m[c]  = ~bus.cnt_n_reset_o;
            done_m[c] = bus.done_o;
            busy_m[c] = bus.busy_o;
         end
         busy_exp = ((32'h1 << (vecs[i].done_cyc + 1)) - 32'h1) & ~32'h1;
         clr_exp  = (vecs[i].len == 8'd0) ? 32'h0 : 32'h2;
         check($sformatf("v%0d_ce", i), ce_m, vecs[i].ce_mask);
         check($sformatf("v%0d_clear", i), clr_m, clr_exp);
         check($sformatf("v%0d_done", i), done_m, 32'h1 << vecs[i].done_cyc);
         check($sformatf("v%0d_busy", i), busy_m, busy_exp);
         check($sformatf("v%0d_bursts", i), 32'(bus.bursts_o), 32'(vecs[i].bursts));
         check($sformatf("v%0d_active", i), 32'(bus.active_ticks_o), 32'(vecs[i].act_ticks));
      end

      // Periodic: CLEAR, CE, CE, GAP repeating; stray start while busy is ignored.
      ce_m = '0; clr_m = '0; done_m = '0;
      kick(8'd0, 8'd2, 8'd1, 1'b1, 1'b0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         ce_m[c]   = bus.ce_o;
         clr_m[c]  = ~bus.cnt_n_reset_o;
         done_m[c] = bus.done_o;
         bus.start_i = (c >= 5 && c <= 8);
      end
      check("per_ce", ce_m, 32'h0000_CCCC);
      check("per_clear", clr_m, 32'h0000_2222);
      check("per_done", done_m, 32'h0);
      check("per_bursts", 32'(bus.bursts_o), 32'd4);
      bus.stop_i = 1'b1;
      @(negedge clk);
      bus.stop_i = 1'b0;
      check("per_stop_busy", 32'(bus.busy_o), 32'd0);
      check("per_stop_bursts", 32'(bus.bursts_o), 32'd4);

      // Abort during RUN after 2 of 5 CEs (prescale 1: CEs in cycles 3 and 5).
      n_ce = 0;
      kick(8'd1, 8'd5, 8'd0, 1'b0, 1'b1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (bus.ce_o) n_ce++;
      end
      check("stop_ce_count", 32'(n_ce), 32'd2);
      bus.stop_i = 1'b1;
      @(negedge clk);
      bus.stop_i = 1'b0;
      check("stop_busy", 32'(bus.busy_o), 32'd0);
      check("stop_active", 32'(bus.active_ticks_o), 32'd2);
      check("stop_bursts", 32'(bus.bursts_o), 32'd0);
      bad = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.ce_o || bus.done_o || bus.busy_o) bad = 1'b1;
      end
      check("stop_quiet", 32'(bad), 32'd0);

      // start and stop together: stop wins.
      @(negedge clk);
      bus.length_i = 8'd3;
      bus.start_i  = 1'b1;
      bus.stop_i   = 1'b1;
      @(negedge clk);
      bus.start_i  = 1'b0;
      bus.stop_i   = 1'b0;
      check("startstop_busy", 32'(bus.busy_o), 32'd0);
      check("startstop_clear", 32'(bus.cnt_n_reset_o), 32'd1);

      // Reset in the middle of a gap (cycles 4..6 are GAP).
      kick(8'd0, 8'd2, 8'd3, 1'b1, 1'b1);
      for (int c = 1; c <= 5; c++) @(negedge clk);
      check("gap_pre_bursts", 32'(bus.bursts_o), 32'd1);
      check("gap_pre_active", 32'(bus.active_ticks_o), 32'd2);
      check("gap_pre_busy", 32'(bus.busy_o), 32'd1);
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      check("gap_rst_busy", 32'(bus.busy_o), 32'd0);
      check("gap_rst_bursts", 32'(bus.bursts_o), 32'd0);
      check("gap_rst_active", 32'(bus.active_ticks_o), 32'd0);
      check("gap_rst_cnt_n_reset", 32'(bus.cnt_n_reset_o), 32'd1);

      // Saturation: ~310 single-tick bursts with no gap.
      kick(8'd0, 8'd1, 8'd0, 1'b1, 1'b1);
      repeat (620) @(negedge clk);
      check("sat_bursts", 32'(bus.bursts_o), 32'd255);
      check("sat_active", 32'(bus.active_ticks_o), 32'd255);
      bus.stop_i = 1'b1;
      @(negedge clk);
      bus.stop_i = 1'b0;
      check("sat_stop_busy", 32'(bus.busy_o), 32'd0);
      check("sat_hold_bursts", 32'(bus.bursts_o), 32'd255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
